cv32e40p_obi_mem_responder: RTL and testbench

- Memory-side responder for the core's OBI instruction/data bus (req/gnt/rvalid).
- Drives gnt_o and rvalid_o/rdata_o back to the core's instr_* or data_* master port.
- Services reads and byte-enabled writes from an internal word array.
- Controllable grant and response stalls let formal/mutation harnesses and directed benches exercise every legal OBI timing at the core boundary.

---
 rtl/cv32e40p_obi_mem_responder.sv | 140 ++++++++++++++
 tb/tb_cv32e40p_obi_mem_responder.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_obi_mem_responder.sv
// OBI memory responder: services core reads/byte-enabled writes from a word array, in-order responses.
// Latency: grant in cycle T gives rvalid_o in cycle T+RESP_LATENCY when nothing stalls; one response per cycle.
// Backpressure: gnt_o drops when MAX_OUTSTANDING transactions are unresponded or gnt_stall_i is high; resp_stall_i holds responses.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   req_i/gnt_o                   OBI address phase handshake
//   addr_i, we_i, be_i, wdata_i   address-phase payload
//   rvalid_o, rdata_o             OBI response phase (no ready; always accepted)
//   gnt_stall_i, resp_stall_i     timing controls for harnesses
//   outstanding_o                 granted transactions whose rvalid cycle has not yet completed
module cv32e40p_obi_mem_responder #(
  parameter int unsigned MEM_WORDS_LOG2  = 8,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned RESP_LATENCY    = 1,
  parameter logic [31:0] OOR_RDATA       = 32'hDEAD_BEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        gnt_o,
  input  logic [31:0] addr_i,
  input  logic        we_i,
  input  logic [3:0]  be_i,
  input  logic [31:0] wdata_i,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  input  logic        gnt_stall_i,
  input  logic        resp_stall_i,
  output logic [2:0]  outstanding_o
);

  localparam int unsigned MEM_WORDS = 1 << MEM_WORDS_LOG2;
  // Slot arrays are sized for the largest legal depth so a 2-bit pointer
  // always indexes them exactly; only MAX_OUTSTANDING slots are used.
  localparam int unsigned FIFO_SLOTS = 4;

  logic [31:0] mem_q      [MEM_WORDS];
  logic [31:0] fifo_dat_q [FIFO_SLOTS];
  logic [2:0]  fifo_age_q [FIFO_SLOTS];
  logic [1:0]  rd_ptr_q, wr_ptr_q;
  logic [2:0]  fifo_cnt_q;
  logic [2:0]  outstanding_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;

  logic [MEM_WORDS_LOG2-1:0] word_idx;
  logic        in_range;
  logic        push;
  logic [31:0] push_dat;
  logic        fifo_empty;
  logic        head_vld;
  logic [31:0] head_dat;
  logic [2:0]  head_age;
  logic        pop;
  logic        fifo_wr;
  logic        fifo_rd;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'(MAX_OUTSTANDING - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  function automatic logic [2:0] age_inc(input logic [2:0] a);
    return (a == 3'd7) ? 3'd7 : a + 3'd1;
  endfunction

  // The slot is freed only after the rvalid cycle, so a retiring response
  // never lets a grant through in the same cycle.
  assign gnt_o = !rst_i && !gnt_stall_i && (outstanding_q < 3'(MAX_OUTSTANDING));
  assign push  = req_i && gnt_o;

  assign word_idx = addr_i[MEM_WORDS_LOG2+1:2];
  assign in_range = (addr_i >> (MEM_WORDS_LOG2 + 2)) == 32'd0;
  assign push_dat = we_i ? 32'd0 : (in_range ? mem_q[word_idx] : OOR_RDATA);

  // Ages are judged as they will be after this edge: a stored entry grows by
  // one, and an entry granted this cycle counts as age 1. An empty FIFO lets
  // the incoming entry pop straight through, which is what makes
  // RESP_LATENCY=1 answer in the very next cycle.
  assign fifo_empty = (fifo_cnt_q == 3'd0);
  assign head_vld   = !fifo_empty || push;
  assign head_dat   = fifo_empty ? push_dat : fifo_dat_q[rd_ptr_q];
  assign head_age   = fifo_empty ? 3'd1 : age_inc(fifo_age_q[rd_ptr_q]);
  assign pop        = head_vld && (head_age >= 3'(RESP_LATENCY)) && !resp_stall_i;
  assign fifo_wr    = push && !(pop && fifo_empty);
  assign fifo_rd    = pop && !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q      <= 2'd0;
      wr_ptr_q      <= 2'd0;
      fifo_cnt_q    <= 3'd0;
      outstanding_q <= 3'd0;
      rvalid_q      <= 1'b0;
      rdata_q       <= 32'd0;
    end else begin
      if (fifo_wr) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fifo_rd) rd_ptr_q <= ptr_inc(rd_ptr_q);
      fifo_cnt_q    <= fifo_cnt_q + {2'b00, fifo_wr} - {2'b00, fifo_rd};
      outstanding_q <= outstanding_q + {2'b00, push} - {2'b00, rvalid_q};
      rvalid_q      <= pop;
      if (pop) rdata_q <= head_dat;
    end
  end

  // Payload and age need no reset: the count and pointers define which
  // slots are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < FIFO_SLOTS; i++) begin
      fifo_age_q[i] <= age_inc(fifo_age_q[i]);
    end
    if (fifo_wr) begin
      fifo_dat_q[wr_ptr_q] <= push_dat;
      fifo_age_q[wr_ptr_q] <= 3'd1;
    end
  end

  // Memory survives reset; out-of-range writes are dropped but still answered.
  always_ff @(posedge clk_i) begin
    if (push && we_i && in_range) begin
      for (int k = 0; k < 4; k++) begin
        if (be_i[k]) mem_q[word_idx][8*k +: 8] <= wdata_i[8*k +: 8];
      end
    end
  end

  assign rvalid_o      = rvalid_q;
  assign rdata_o       = rdata_q;
  assign outstanding_o = outstanding_q;

  a_outstanding_bound: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q <= 3'(MAX_OUTSTANDING));
  a_pop_needs_entry: assert property (@(posedge clk_i) disable iff (rst_i)
    pop |-> head_vld);
  // Every unresponded grant is either queued or on the bus right now, so
  // rvalid pulses match grants one-for-one outside of reset.
  a_grant_response_balance: assert property (@(posedge clk_i) disable iff (rst_i)
    outstanding_q == fifo_cnt_q + {2'b00, rvalid_q});

endmodule

// File: tb/tb_cv32e40p_obi_mem_responder.sv
module tb_cv32e40p_obi_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  // Main DUT: MAX_OUTSTANDING=2, RESP_LATENCY=1
  logic        req, we, gstall, rstall;
  logic [31:0] addr, wdata;
  logic [3:0]  be;
  logic        gnt, rvalid;
  logic [31:0] rdata;
  logic [2:0]  outs;
  // Second DUT: MAX_OUTSTANDING=2, RESP_LATENCY=3
  logic        req3, we3, gstall3, rstall3;
  logic [31:0] addr3, wdata3;
  logic [3:0]  be3;
  logic        gnt3, rvalid3;
  logic [31:0] rdata3;
  logic [2:0]  outs3;

  cv32e40p_obi_mem_responder #(.MEM_WORDS_LOG2(8), .MAX_OUTSTANDING(2), .RESP_LATENCY(1),
                               .OOR_RDATA(32'hDEAD_BEEF)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata),
    .gnt_stall_i(gstall), .resp_stall_i(rstall), .outstanding_o(outs));

  cv32e40p_obi_mem_responder #(.MEM_WORDS_LOG2(8), .MAX_OUTSTANDING(2), .RESP_LATENCY(3),
                               .OOR_RDATA(32'hDEAD_BEEF)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_i(req3), .gnt_o(gnt3), .addr_i(addr3), .we_i(we3),
    .be_i(be3), .wdata_i(wdata3), .rvalid_o(rvalid3), .rdata_o(rdata3),
    .gnt_stall_i(gstall3), .resp_stall_i(rstall3), .outstanding_o(outs3));

  typedef struct {
    logic        rst, req, we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        gs, rs;
    logic        egnt, ervalid;
    logic [31:0] erdata;
    logic [2:0]  eout;
  } vec_t;

  vec_t tbl[$];
  int   nvec = 0;
  int   nerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic addv(input logic r, input logic q, input logic w, input logic [31:0] a,
                      input logic [3:0] b, input logic [31:0] d, input logic gs, input logic rs,
                      input logic eg, input logic ev, input logic [31:0] ed, input logic [2:0] eo);
    vec_t v;
    v.rst = r; v.req = q; v.we = w; v.addr = a; v.be = b; v.wdata = d;
    v.gs = gs; v.rs = rs; v.egnt = eg; v.ervalid = ev; v.erdata = ed; v.eout = eo;
    tbl.push_back(v);
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req = 0; we = 0; addr = 0; be = 0; wdata = 0; gstall = 0; rstall = 0;
    req3 = 0; we3 = 0; addr3 = 0; be3 = 0; wdata3 = 0; gstall3 = 0; rstall3 = 0;

    //   rst req we addr          be    wdata         gs rs | gnt rv rdata         out
    // write then read, latency 1
    addv(0, 1, 1, 32'h10,  4'hF, 32'h1234_5678, 0, 0,   1, 0, 32'h0,         0); // c0
    addv(0, 1, 0, 32'h10,  4'h0, 32'h0,         0, 0,   1, 1, 32'h0,         1); // c1
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'h1234_5678, 1); // c2
    // byte enables
    addv(0, 1, 1, 32'h20,  4'hF, 32'hAABB_CCDD, 0, 0,   1, 0, 32'h1234_5678, 0); // c3
    addv(0, 1, 1, 32'h20,  4'h5, 32'h1122_3344, 0, 0,   1, 1, 32'h0,         1); // c4
    addv(0, 1, 0, 32'h20,  4'h0, 32'h0,         0, 0,   1, 1, 32'h0,         1); // c5
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'hAA22_CC44, 1); // c6
    // out of range: 0x400 aliases word 0 in the index bits but must not touch it
    addv(0, 1, 1, 32'h0,   4'hF, 32'hCAFE_F00D, 0, 0,   1, 0, 32'hAA22_CC44, 0); // c7
    addv(0, 1, 0, 32'h400, 4'h0, 32'h0,         0, 0,   1, 1, 32'h0,         1); // c8
    addv(0, 1, 1, 32'h400, 4'hF, 32'h5555_5555, 0, 0,   1, 1, 32'hDEAD_BEEF, 1); // c9
    addv(0, 1, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'h0,         1); // c10
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'hCAFE_F00D, 1); // c11
    // grant stall: request not taken
    addv(0, 1, 0, 32'h10,  4'h0, 32'h0,         1, 0,   0, 0, 32'hCAFE_F00D, 0); // c12
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 0, 32'hCAFE_F00D, 0); // c13
    // response stall for 4 cycles, with a later write to the same word
    addv(0, 1, 0, 32'h10,  4'h0, 32'h0,         0, 1,   1, 0, 32'hCAFE_F00D, 0); // c14
    addv(0, 1, 1, 32'h10,  4'hF, 32'h0BAD_F00D, 0, 1,   1, 0, 32'hCAFE_F00D, 1); // c15
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 1,   0, 0, 32'hCAFE_F00D, 2); // c16
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 1,   0, 0, 32'hCAFE_F00D, 2); // c17
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   0, 0, 32'hCAFE_F00D, 2); // c18
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   0, 1, 32'h1234_5678, 2); // c19
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'h0,         1); // c20
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 0, 32'h0,         0); // c21
    addv(0, 1, 0, 32'h10,  4'h0, 32'h0,         0, 0,   1, 0, 32'h0,         0); // c22
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'h0BAD_F00D, 1); // c23
    // reset with two reads pending
    addv(0, 1, 0, 32'h10,  4'h0, 32'h0,         0, 1,   1, 0, 32'h0BAD_F00D, 0); // c24
    addv(0, 1, 0, 32'h20,  4'h0, 32'h0,         0, 1,   1, 0, 32'h0BAD_F00D, 1); // c25
    addv(1, 0, 0, 32'h0,   4'h0, 32'h0,         0, 1,   0, 0, 32'h0BAD_F00D, 2); // c26
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 0, 32'h0,         0); // c27
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 0, 32'h0,         0); // c28
    addv(0, 1, 0, 32'h20,  4'h0, 32'h0,         0, 0,   1, 0, 32'h0,         0); // c29
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 1, 32'hAA22_CC44, 1); // c30
    addv(0, 0, 0, 32'h0,   4'h0, 32'h0,         0, 0,   1, 0, 32'hAA22_CC44, 0); // c31

    // power-on reset: two edges with rst high
    step;
    @(negedge clk);
    chk("reset_gnt", {31'd0, gnt}, 32'd0);
    chk("reset_gnt3", {31'd0, gnt3}, 32'd0);
    step;
    rst = 1'b0;
    @(negedge clk);
    chk("post_reset_gnt", {31'd0, gnt}, 32'd1);
    chk("post_reset_rvalid", {31'd0, rvalid}, 32'd0);
    chk("post_reset_rdata", rdata, 32'd0);
    chk("post_reset_outstanding", {29'd0, outs}, 32'd0);

    foreach (tbl[i]) begin
      step;
      rst = tbl[i].rst; req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr;
      be = tbl[i].be; wdata = tbl[i].wdata; gstall = tbl[i].gs; rstall = tbl[i].rs;
      @(negedge clk);
      chk($sformatf("c%0d_gnt", i),         {31'd0, gnt},    {31'd0, tbl[i].egnt});
      chk($sformatf("c%0d_rvalid", i),      {31'd0, rvalid}, {31'd0, tbl[i].ervalid});
      chk($sformatf("c%0d_rdata", i),       rdata,           tbl[i].erdata);
      chk($sformatf("c%0d_outstanding", i), {29'd0, outs},   {29'd0, tbl[i].eout});
    end
    step;
    req = 0; we = 0; addr = 0; rstall = 0; gstall = 0;

    // Outstanding limit with latency 3: reads of an out-of-range address held high.
    req3 = 1'b1; addr3 = 32'h400;
    @(negedge clk);
    chk("lim_c0_gnt", {31'd0, gnt3}, 32'd1);
    chk("lim_c0_out", {29'd0, outs3}, 32'd0);
    step; @(negedge clk);
    chk("lim_c1_gnt", {31'd0, gnt3}, 32'd1);
    chk("lim_c1_rvalid", {31'd0, rvalid3}, 32'd0);
    step; @(negedge clk);
    chk("lim_c2_gnt", {31'd0, gnt3}, 32'd0);
    chk("lim_c2_out", {29'd0, outs3}, 32'd2);
    chk("lim_c2_rvalid", {31'd0, rvalid3}, 32'd0);
    step; @(negedge clk);
    chk("lim_c3_rvalid", {31'd0, rvalid3}, 32'd1);
    chk("lim_c3_rdata", rdata3, 32'hDEAD_BEEF);
    chk("lim_c3_gnt", {31'd0, gnt3}, 32'd0);
    chk("lim_c3_out", {29'd0, outs3}, 32'd2);
    step; @(negedge clk);
    chk("lim_c4_gnt", {31'd0, gnt3}, 32'd1);
    chk("lim_c4_rvalid", {31'd0, rvalid3}, 32'd1);
    chk("lim_c4_out", {29'd0, outs3}, 32'd1);
    step;
    req3 = 1'b0;
    @(negedge clk);
    chk("lim_c5_rvalid", {31'd0, rvalid3}, 32'd0);
    chk("lim_c5_out", {29'd0, outs3}, 32'd1);
    step; @(negedge clk);
    chk("lim_c6_rvalid", {31'd0, rvalid3}, 32'd0);
    step; @(negedge clk);
    chk("lim_c7_rvalid", {31'd0, rvalid3}, 32'd1);
    step; @(negedge clk);
    chk("lim_c8_rvalid", {31'd0, rvalid3}, 32'd0);
    chk("lim_c8_out", {29'd0, outs3}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
